// File: rtl/cmp_pkg.sv
// Shared constants and types for the sliced sequential magnitude comparator.
package cmp_pkg;

    localparam int SLICE_W = 2;
    localparam int STATE_W = 1;

    localparam logic [STATE_W-1:0] IDLE = 1'b0;
    localparam logic [STATE_W-1:0] RUN  = 1'b1;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    // A final result is either a decisive slice (g or l) or all slices equal.
    function automatic cmp_res_t res_from_slice(input logic g, input logic l);
        cmp_res_t r;
        r.gt = g;
        r.lt = l;
        r.eq = ~(g | l);
        return r;
    endfunction

endpackage

// File: rtl/comparator.sv
// Combinational unsigned compare of one 2-bit operand slice.
module comparator
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output logic               g_o,
    output logic               e_o,
    output logic               l_o
);

    assign g_o = (a_i > b_i);
    assign e_o = (a_i == b_i);
    assign l_o = (a_i < b_i);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequential MSB-first magnitude comparator: walks 2-bit slices through one
// shared slice comparator and stops at the first slice that differs.
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int NSLICE = WIDTH / SLICE_W,
    localparam int SW     = $clog2(NSLICE) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [SW-1:0]    steps
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SW-1:0]      steps_q, steps_d;
    cmp_res_t           res_q, res_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic               sl_g, sl_e, sl_l;

    // Slice multiplexer in front of the single shared comparator.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    comparator u_slice_cmp (
        .a_i (a_sl),
        .b_i (b_sl),
        .g_o (sl_g),
        .e_o (sl_e),
        .l_o (sl_l)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        steps_d = steps_q;
        res_d   = res_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(NSLICE - 1);
                    steps_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                steps_d = steps_q + 1'b1;
                if (sl_g || sl_l) begin
                    res_d   = res_from_slice(sl_g, sl_l);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (sl_e && (idx_q == '0)) begin
                    res_d   = res_from_slice(1'b0, 1'b0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Busy is registered from the next state so it tracks RUN exactly.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            steps_q <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            steps_q <= steps_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = res_q.gt;
    assign eq    = res_q.eq;
    assign lt    = res_q.lt;
    assign steps = steps_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed and randomized bench for cmp_seq_ctrl against a plain-arithmetic model.
module tb_cmp_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;
    localparam int SW     = $clog2(NSLICE) + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy, done, gt, eq, lt;
    logic [SW-1:0]    steps;

    int checks = 0;
    int errors = 0;

    logic exp_gt, exp_eq, exp_lt;
    int   exp_steps;

    cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt),
        .steps (steps)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned relation, and steps = slices scanned from the MSB
    // down to (and including) the slice holding the highest differing bit.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
        logic [WIDTH-1:0] x;
        int hi;
        exp_gt = (ma > mb);
        exp_eq = (ma == mb);
        exp_lt = (ma < mb);
        x  = ma ^ mb;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) hi = i;
        exp_steps = (hi < 0) ? NSLICE : NSLICE - hi / 2;
    endtask

    task automatic check_result(input string tag);
        check({tag, "_gt"}, gt, exp_gt);
        check({tag, "_eq"}, eq, exp_eq);
        check({tag, "_lt"}, lt, exp_lt);
        check({tag, "_onehot"}, 32'(gt) + 32'(eq) + 32'(lt), 1);
    endtask

    // Called at a sample point with the DUT in IDLE; returns at the done sample.
    task automatic launch(input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                          input bit scramble, input string tag);
        int cyc;
        int busy_cnt;
        model(na, nb);
        a = na;
        b = nb;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < NSLICE + 3) begin
            if (busy) busy_cnt++;
            if (scramble) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            tick();
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, cyc, exp_steps);
        check({tag, "_busycycles"}, busy_cnt, exp_steps);
        check({tag, "_steps"}, steps, exp_steps);
        check({tag, "_busy_at_done"}, busy, 0);
        check_result(tag);
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_hold_steps"}, steps, exp_steps);
        check_result({tag, "_hold"});
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gt", gt, 0);
        check("rst_eq", eq, 0);
        check("rst_lt", lt, 0);
        check("rst_steps", steps, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        // Early exit on the MSB slice
        launch(8'hB4, 8'h34, 1'b0, "msb_gt");
        idle_check("msb_gt");

        // Full scan of equal operands
        launch(8'h5A, 8'h5A, 1'b0, "equal");
        idle_check("equal");

        // Decided on the LSB slice, then back-to-back start in the done cycle
        launch(8'h12, 8'h13, 1'b0, "lsb_lt");
        launch(8'h13, 8'h12, 1'b0, "b2b_gt");
        idle_check("b2b_gt");

        // Start while busy is ignored
        model(8'h00, 8'hFF);
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'h00;
        check("ign_busy", busy, 1);
        tick();
        start = 1'b0;
        check("ign_done", done, 1);
        check("ign_steps", steps, 1);
        check_result("ign");
        tick();
        check("ign_no_restart", busy, 0);
        check("ign_done_low", done, 0);
        check_result("ign_hold");

        // Reset in the second RUN cycle aborts the compare
        a = 8'hC3;
        b = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_gt", gt, 0);
        check("abort_eq", eq, 0);
        check("abort_lt", lt, 0);
        check("abort_steps", steps, 0);
        tick();
        rst_n = 1'b1;
        check("abort_done_in_rst", done, 0);
        tick();
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        launch(8'h01, 8'h00, 1'b0, "after_rst");
        idle_check("after_rst");

        // Randomized compares, with operand churn during RUN and mixed gaps
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0: rb = WIDTH'($urandom);
                1: rb = ra;
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            launch(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
        end
        idle_check("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Derived constant NSLICE = WIDTH/2, the number of 2-bit slices; SW = $clog2(NSLICE)+1, the width of the step counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a compare; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, sampled on the accepted start edge.
REQ-007 b  input  WIDTH  operand B, sampled on the accepted start edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when a result is registered.
REQ-010 gt  output  1  A > B, unsigned.
REQ-011 eq  output  1  A == B.
REQ-012 lt  output  1  A < B, unsigned.
REQ-013 steps  output  SW  number of slices examined for the last result (1..NSLICE).

Function
REQ-014 FSM SHALL have two states: IDLE and RUN.
REQ-015 IDLE with start=1: latch a and b, set slice index idx=NSLICE-1 (MSB slice), clear steps, go to RUN; gt/eq/lt hold their previous values until the new result.
REQ-016 RUN, each cycle: drive the 2-bit comparator with a[2*idx+1:2*idx] and b[2*idx+1:2*idx], and increment steps.
REQ-017 RUN, slice g=1 or l=1: register gt=g, lt=l, eq=0, pulse done, go to IDLE (early exit).
REQ-018 RUN, slice e=1 with idx==0: register eq=1, gt=0, lt=0, pulse done, go to IDLE.
REQ-019 RUN, slice e=1 with idx>0: decrement idx, stay in RUN.
REQ-020 Latency: with start accepted at edge k, the result and done SHALL be visible after edge k+j, where j is the steps value (1..NSLICE); done SHALL be high for exactly one cycle.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the latched operands or idx.
REQ-022 start in the cycle done=1 (state IDLE) SHALL be accepted; back-to-back compares need no idle gap.
REQ-023 Exactly one of gt/eq/lt SHALL be 1 after the first completed compare, and all three SHALL hold until the next result.
REQ-024 Changes on a or b after acceptance SHALL NOT affect the running compare.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, steps=0, idx=0, and clear the latched operands.
REQ-026 A reset during RUN SHALL abort the compare with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-027 Shared package cmp_pkg SHALL hold the state encodings (IDLE, RUN) and the slice-width constant 2.
REQ-028 The per-slice compare SHALL be a single instance of the team's existing 2-bit comparator module comparator, fed by a slice multiplexer; no second compare datapath.
REQ-029 Synthesizable with no latches; all outputs SHALL be registered.

Verification (WIDTH=8)
REQ-030 a=8'hB4, b=8'h34, start -> after 1 cycle: done=1, gt=1, eq=0, lt=0, steps=1.
REQ-031 a=b=8'h5A, start -> after 4 cycles: done=1, eq=1, gt=0, lt=0, steps=4; busy high for 4 cycles.
REQ-032 a=8'h12, b=8'h13, start -> after 4 cycles: lt=1, steps=4; then a=8'h13, b=8'h12 with start in the done cycle -> gt=1, steps=4.
REQ-033 a=8'h00, b=8'hFF, start; pulse start with a=8'hFF, b=8'h00 one cycle later -> second start ignored; result lt=1, steps=1.
REQ-034 a=b=8'hC3, start; rst_n=0 in the second RUN cycle -> all outputs 0 immediately, no done pulse; then a=8'h01, b=8'h00, start -> gt=1, steps=4.
